// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter around the 4:1 mux.
// Arbiter state, requester index constants and owner-to-select mapping.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  // Owner index to mux selects {s2,s1}; mux input order matches requester order.
  function automatic logic [1:0] sel_of(input logic [1:0] owner);
    return owner;
  endfunction

  function automatic logic [3:0] onehot_of(input logic [1:0] owner);
    return 4'b0001 << owner;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// Behavioral 4:1 single-bit mux used as the arbiter datapath.
// Select {s2,s1}: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
module mux4
  import mux_rr_arbiter_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s1,
  input  logic s2,
  output logic y
);

  // Pick one data input from the two select bits.
  always_comb begin
    y = 1'b0;
    case ({s2, s1})
      REQ_A:   y = a;
      REQ_B:   y = b;
      REQ_C:   y = c;
      REQ_D:   y = d;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin winner search over four requesters.
// Scans from (last_i+1) mod 4, wrapping; any_o flags that some request exists.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] win_o,
  output logic       any_o
);

  logic [1:0] idx;

  // First asserted request after last_i; last_i itself is examined last.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_i + 2'(k);
      if (!any_o && req_i[idx]) begin
        win_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// Grants are held for at most MAX_HOLD cycles under contention; the mux output
// is registered with a valid flag. Define MUX_STATS_EN to add per-requester
// saturating grant counters on grant_cnt.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s2,
  output logic       y,
  output logic       y_valid,
  output logic       busy
`ifdef MUX_STATS_EN
  ,
  output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              y_q, y_d;
  logic              yv_q, yv_d;
  logic              busy_q;
  logic              new_grant;
  logic [1:0]        pick_last;
  logic [1:0]        win;
  logic              any_req;
  logic              others;
  logic              mux_y;

  // While granted, search from the current owner so a release rotates onward.
  assign pick_last = (state_q == GRANT) ? owner_q : last_q;
  assign others    = |(req & ~onehot_of(owner_q));

  rr_pick4 u_pick (
    .req_i  (req),
    .last_i (pick_last),
    .win_o  (win),
    .any_o  (any_req)
  );

  mux4 u_mux (
    .a  (din[0]),
    .b  (din[1]),
    .c  (din[2]),
    .d  (din[3]),
    .s1 (sel_q[0]),
    .s2 (sel_q[1]),
    .y  (mux_y)
  );

  // Next-state: grant, hold with bounded burst, release or switch.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d   = win;
          hold_d    = '0;
          state_d   = GRANT;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (req[owner_q] && (hold_q != HOLD_LAST || !others)) begin
          if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        end else begin
          last_d = owner_q;
          hold_d = '0;
          if (any_req) begin
            owner_d   = win;
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? onehot_of(owner_d) : '0;
    sel_d = (state_d == GRANT) ? sel_of(owner_d) : '0;
    y_d   = (state_q == GRANT) ? mux_y : 1'b0;
    yv_d  = (state_q == GRANT);
  end

  // Arbiter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= REQ_D;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      busy_q  <= (state_d == GRANT);
    end
  end

  assign gnt     = gnt_q;
  assign s1      = sel_q[0];
  assign s2      = sel_q[1];
  assign y       = y_q;
  assign y_valid = yv_q;
  assign busy    = busy_q;

`ifdef MUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];

  // Count new grants per requester, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (new_grant && cnt_q[owner_d] != '1) begin
      cnt_q[owner_d] <= cnt_q[owner_d] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  // Counter width only shapes hardware in the statistics build.
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule
